// File: rtl/ps2_pkg.sv
// Shared PS/2 frame constants and the frame-check helper used by the keyboard receiver.
package ps2_pkg;

    localparam int         PS2_FRAME_BITS = 11;
    localparam logic       PS2_START_BIT  = 1'b0;
    localparam logic       PS2_STOP_BIT   = 1'b1;
    localparam logic [7:0] BREAK_PREFIX   = 8'hF0;
    localparam logic [7:0] EXT_PREFIX     = 8'hE0;

    // Start must be low, stop high, and bits 1..9 (data + parity) carry odd parity.
    function automatic logic frame_ok(input logic [PS2_FRAME_BITS-1:0] f);
        return (f[0] == PS2_START_BIT) && (f[PS2_FRAME_BITS-1] == PS2_STOP_BIT) && (^f[9:1]);
    endfunction

endpackage

// File: rtl/ps2_kbd_receiver_byte_fifo.sv
// Byte FIFO with extra-MSB pointers; read data is combinational from registered storage.
module byte_fifo #(
    parameter int DEPTH_LOG2 = 3,
    parameter int DATA_W     = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                push,
    input  logic                pop,
    input  logic [DATA_W-1:0]   din,
    output logic [DATA_W-1:0]   dout,
    output logic                empty,
    output logic                full,
    output logic [DEPTH_LOG2:0] level
);

    logic [DEPTH_LOG2:0] wr_ptr;
    logic [DEPTH_LOG2:0] rd_ptr;
    logic [DATA_W-1:0]   mem [2**DEPTH_LOG2];
    logic                do_push;
    logic                do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
                     (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);
    assign do_pop  = pop & ~empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign do_push = push & (~full | do_pop);
    assign level   = wr_ptr - rd_ptr;
    assign dout    = empty ? '0 : mem[rd_ptr[DEPTH_LOG2-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[DEPTH_LOG2-1:0]] <= din;
    end

endmodule

// File: rtl/ps2_kbd_receiver.sv
// PS/2 keyboard receiver: pin synchronisers, 11-bit frame capture with timeout,
// frame checking and a scan-code FIFO popped by a one-cycle request.
module ps2_kbd_receiver
    import ps2_pkg::*;
#(
    parameter int DEPTH_LOG2  = 3,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ps2_clk,
    input  logic                ps2_data,
    input  logic                nextdata,
    output logic [7:0]          data,
    output logic                ready,
    output logic [DEPTH_LOG2:0] level,
    output logic                overflow,
    output logic                frame_err
);

    localparam int         TW       = $clog2(TIMEOUT_CYC + 1);
    localparam logic [3:0] LAST_BIT = 4'(PS2_FRAME_BITS - 1);

    logic                      ps2_clk_p0, ps2_clk_p1, ps2_clk_p2;
    logic                      ps2_data_p0, ps2_data_p1, ps2_data_p2;
    logic                      fall;
    logic                      bit_in;
    logic [3:0]                bit_cnt;
    logic [TW-1:0]             tcnt;
    logic [PS2_FRAME_BITS-2:0] sreg;
    logic [PS2_FRAME_BITS-1:0] frame;
    logic                      eval;
    logic                      valid;
    logic                      pop_ok;
    logic                      push;
    logic                      fifo_empty;
    logic                      fifo_full;

    // Stage p0..p2: metastability chain; idle-high reset avoids a false edge after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            {ps2_clk_p0, ps2_clk_p1, ps2_clk_p2}    <= 3'b111;
            {ps2_data_p0, ps2_data_p1, ps2_data_p2} <= 3'b111;
        end else begin
            {ps2_clk_p0, ps2_clk_p1, ps2_clk_p2}    <= {ps2_clk, ps2_clk_p0, ps2_clk_p1};
            {ps2_data_p0, ps2_data_p1, ps2_data_p2} <= {ps2_data, ps2_data_p0, ps2_data_p1};
        end
    end

    assign fall   = ps2_clk_p2 & ~ps2_clk_p1;
    assign bit_in = ps2_data_p2;
    assign eval   = fall && (bit_cnt == LAST_BIT);
    assign frame  = {bit_in, sreg};
    assign valid  = frame_ok(frame);
    assign pop_ok = nextdata & ~fifo_empty;
    assign push   = eval & valid & (~fifo_full | pop_ok);

    // Frame shift register: LSB first, so bit 0 ends at sreg[0] after ten shifts.
    always_ff @(posedge clk) begin
        if (fall) sreg <= {bit_in, sreg[PS2_FRAME_BITS-2:1]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt   <= '0;
            tcnt      <= '0;
            overflow  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= eval & ~valid;
            if (eval && valid && fifo_full && !pop_ok) overflow <= 1'b1;
            if (fall) begin
                tcnt    <= '0;
                bit_cnt <= eval ? 4'd0 : bit_cnt + 4'd1;
            end else if (bit_cnt != 4'd0) begin
                // A stalled partial frame is abandoned quietly.
                if (tcnt == TW'(TIMEOUT_CYC - 1)) begin
                    bit_cnt <= '0;
                    tcnt    <= '0;
                end else begin
                    tcnt <= tcnt + 1'b1;
                end
            end else begin
                tcnt <= '0;
            end
        end
    end

    byte_fifo #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .DATA_W     (8)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (nextdata),
        .din   (frame[8:1]),
        .dout  (data),
        .empty (fifo_empty),
        .full  (fifo_full),
        .level (level)
    );

    assign ready = ~fifo_empty;

endmodule
